// File: rtl/unidade_contador_programa.sv
// Program-counter unit for the iZero datapath: sequential fetch, branches, jumps,
// a circular return-address stack, interrupt vectoring with EPC, and stall/halt.
module unidade_contador_programa #(
  parameter int LARGURA            = 26,
  parameter int INCREMENTO         = 1,
  parameter int ENDERECO_RESET     = 0,
  parameter int VETOR_INTERRUPCAO  = 16,
  parameter int PROFUNDIDADE_PILHA = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [LARGURA-1:0] endereco,
  input  logic [LARGURA-1:0] deslocamento,
  input  logic               desvio,
  input  logic               salto,
  input  logic               salto_link,
  input  logic               retorno,
  input  logic               interrupcao,
  input  logic               eret,
  input  logic               stall,
  input  logic               halt,
  output logic [LARGURA-1:0] pcAtual,
  output logic [LARGURA-1:0] epc,
  output logic               em_interrupcao,
  output logic               parado,
  output logic               pilha_vazia,
  output logic               pilha_cheia,
  output logic               erro_pilha
);

  localparam int PTR_W = $clog2(PROFUNDIDADE_PILHA);
  localparam logic [LARGURA-1:0] INC_L   = LARGURA'(INCREMENTO);
  localparam logic [LARGURA-1:0] RESET_L = LARGURA'(ENDERECO_RESET);
  localparam logic [LARGURA-1:0] VETOR_L = LARGURA'(VETOR_INTERRUPCAO);
  localparam logic [PTR_W:0]     CNT_MAX = (PTR_W+1)'(PROFUNDIDADE_PILHA);
  localparam logic [PTR_W:0]     CNT_UM  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]   PTR_UM  = PTR_W'(1);

  typedef enum logic [1:0] {
    EXECUTANDO = 2'b00,
    TRATANDO   = 2'b01,
    PARADO     = 2'b10
  } estado_t;

  estado_t            estado_r, estado_s;
  logic [LARGURA-1:0] pc_r, pc_s;
  logic [LARGURA-1:0] epc_r, epc_s;
  logic [LARGURA-1:0] pilha_r [PROFUNDIDADE_PILHA];
  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W:0]     cont_r;
  logic               erro_r, erro_s;
  logic               push_s, pop_s;
  logic               vazia_s, cheia_s;
  logic [LARGURA-1:0] pc_seq_s, topo_s;

  assign vazia_s  = (cont_r == '0);
  assign cheia_s  = (cont_r == CNT_MAX);
  assign pc_seq_s = pc_r + INC_L;
  // ptr_r points at the next free slot, so the top lives one below it
  assign topo_s   = pilha_r[ptr_r - PTR_UM];

  // Priority decode of the next PC, state and stack operation
  always_comb begin
    estado_s = estado_r;
    pc_s     = pc_r;
    epc_s    = epc_r;
    erro_s   = erro_r;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    case (estado_r)
      EXECUTANDO, TRATANDO: begin
        if (halt) begin
          estado_s = PARADO;
        end else if (interrupcao && (estado_r == EXECUTANDO)) begin
          epc_s    = pc_r;
          pc_s     = VETOR_L;
          estado_s = TRATANDO;
        end else if (stall) begin
          pc_s = pc_r;
        end else if (eret && (estado_r == TRATANDO)) begin
          pc_s     = epc_r;
          estado_s = EXECUTANDO;
        end else if (salto_link) begin
          push_s = 1'b1;
          pc_s   = endereco;
          if (cheia_s) begin
            erro_s = 1'b1;
          end else begin
            erro_s = erro_r;
          end
        end else if (salto) begin
          pc_s = endereco;
        end else if (desvio) begin
          pc_s = pc_seq_s + deslocamento;
        end else if (retorno) begin
          if (vazia_s) begin
            pc_s   = RESET_L;
            erro_s = 1'b1;
          end else begin
            pc_s  = topo_s;
            pop_s = 1'b1;
          end
        end else begin
          pc_s = pc_seq_s;
        end
      end
      PARADO: begin
        estado_s = PARADO;
      end
      default: begin
        estado_s = PARADO;
      end
    endcase
  end

  // Architectural registers: state, PC, EPC and the sticky stack error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_r <= EXECUTANDO;
      pc_r     <= RESET_L;
      epc_r    <= '0;
      erro_r   <= 1'b0;
    end else begin
      estado_r <= estado_s;
      pc_r     <= pc_s;
      epc_r    <= epc_s;
      erro_r   <= erro_s;
    end
  end

  // Circular return stack; a push when full overwrites the oldest slot
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r  <= '0;
      cont_r <= '0;
      for (int i = 0; i < PROFUNDIDADE_PILHA; i++) begin
        pilha_r[i] <= '0;
      end
    end else if (push_s) begin
      pilha_r[ptr_r] <= pc_seq_s;
      ptr_r          <= ptr_r + PTR_UM;
      cont_r         <= cheia_s ? cont_r : (cont_r + CNT_UM);
    end else if (pop_s) begin
      ptr_r  <= ptr_r - PTR_UM;
      cont_r <= cont_r - CNT_UM;
    end else begin
      ptr_r  <= ptr_r;
      cont_r <= cont_r;
    end
  end

  assign pcAtual        = pc_r;
  assign epc            = epc_r;
  assign em_interrupcao = (estado_r == TRATANDO);
  assign parado         = (estado_r == PARADO);
  assign pilha_vazia    = vazia_s;
  assign pilha_cheia    = cheia_s;
  assign erro_pilha     = erro_r;

endmodule

// File: tb/tb_unidade_contador_programa.sv
// Directed bench for unidade_contador_programa with hand-computed expectations.
module tb_unidade_contador_programa;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [25:0] endereco, deslocamento;
  logic        desvio, salto, salto_link, retorno, interrupcao, eret, stall, halt;
  logic [25:0] pcAtual, epc;
  logic        em_interrupcao, parado, pilha_vazia, pilha_cheia, erro_pilha;

  int n_verif = 0;
  int n_falha = 0;

  unidade_contador_programa dut (
    .clock(clock), .reset_n(reset_n), .endereco(endereco), .deslocamento(deslocamento),
    .desvio(desvio), .salto(salto), .salto_link(salto_link), .retorno(retorno),
    .interrupcao(interrupcao), .eret(eret), .stall(stall), .halt(halt),
    .pcAtual(pcAtual), .epc(epc), .em_interrupcao(em_interrupcao), .parado(parado),
    .pilha_vazia(pilha_vazia), .pilha_cheia(pilha_cheia), .erro_pilha(erro_pilha)
  );

  always #5 clock = ~clock;

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_verif++;
    if (obs !== esp) begin
      n_falha++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    end
  endtask

  task automatic ocioso();
    endereco = 26'h0; deslocamento = 26'h0;
    desvio = 1'b0; salto = 1'b0; salto_link = 1'b0; retorno = 1'b0;
    interrupcao = 1'b0; eret = 1'b0; stall = 1'b0; halt = 1'b0;
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic ir_para(input logic [25:0] alvo);
    ocioso();
    salto = 1'b1; endereco = alvo;
    ciclo();
    ocioso();
  endtask

  initial begin
    ocioso();
    reset_n = 1'b0;
    #3;
    verificar("rst_pc", 32'(pcAtual), 32'h0);
    verificar("rst_epc", 32'(epc), 32'h0);
    verificar("rst_int", 32'(em_interrupcao), 32'h0);
    verificar("rst_parado", 32'(parado), 32'h0);
    verificar("rst_vazia", 32'(pilha_vazia), 32'h1);
    verificar("rst_cheia", 32'(pilha_cheia), 32'h0);
    verificar("rst_erro", 32'(erro_pilha), 32'h0);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      ciclo();
      verificar("inc", 32'(pcAtual), 32'(i));
    end
    // asynchronous reset between edges
    #2; reset_n = 1'b0; #1;
    verificar("rst_async", 32'(pcAtual), 32'h0);
    #1; reset_n = 1'b1;

    ir_para(26'h20);
    desvio = 1'b1; deslocamento = 26'h3FFFFFC;
    ciclo();
    verificar("desvio_neg", 32'(pcAtual), 32'h1D);
    ir_para(26'h3FFFFFF);
    ciclo();
    verificar("wrap", 32'(pcAtual), 32'h0);

    ir_para(26'h5);
    salto_link = 1'b1; endereco = 26'h100;
    ciclo();
    verificar("call_pc", 32'(pcAtual), 32'h100);
    verificar("call_vazia", 32'(pilha_vazia), 32'h0);
    ocioso(); retorno = 1'b1;
    ciclo();
    verificar("ret_pc", 32'(pcAtual), 32'h6);
    verificar("ret_vazia", 32'(pilha_vazia), 32'h1);

    // five nested calls into a depth-4 stack
    for (int i = 0; i < 5; i++) begin
      ocioso(); salto_link = 1'b1; endereco = 26'((i + 2) * 26'h100);
      ciclo();
      if (i == 3) begin
        verificar("cheia", 32'(pilha_cheia), 32'h1);
        verificar("erro_antes", 32'(erro_pilha), 32'h0);
      end
    end
    verificar("call5_pc", 32'(pcAtual), 32'h600);
    verificar("overflow_erro", 32'(erro_pilha), 32'h1);
    verificar("overflow_cheia", 32'(pilha_cheia), 32'h1);
    for (int i = 0; i < 4; i++) begin
      ocioso(); retorno = 1'b1;
      ciclo();
      verificar("ret_aninhado", 32'(pcAtual), 32'h501 - 32'(i) * 32'h100);
    end
    verificar("ret_vazia2", 32'(pilha_vazia), 32'h1);
    ciclo();
    verificar("underflow_pc", 32'(pcAtual), 32'h0);
    verificar("underflow_erro", 32'(erro_pilha), 32'h1);

    ir_para(26'h40);
    interrupcao = 1'b1; stall = 1'b1; salto_link = 1'b1; endereco = 26'h999;
    ciclo();
    verificar("int_pc", 32'(pcAtual), 32'h10);
    verificar("int_epc", 32'(epc), 32'h40);
    verificar("int_flag", 32'(em_interrupcao), 32'h1);
    verificar("int_sem_push", 32'(pilha_vazia), 32'h1);
    ocioso(); interrupcao = 1'b1;
    ciclo();
    verificar("int_aninhada_pc", 32'(pcAtual), 32'h11);
    verificar("int_aninhada_epc", 32'(epc), 32'h40);
    ocioso(); eret = 1'b1;
    ciclo();
    verificar("eret_pc", 32'(pcAtual), 32'h40);
    verificar("eret_flag", 32'(em_interrupcao), 32'h0);

    ir_para(26'h8);
    salto = 1'b1; desvio = 1'b1; endereco = 26'h80; deslocamento = 26'h7;
    ciclo();
    verificar("prio_salto", 32'(pcAtual), 32'h80);
    ir_para(26'h8);
    eret = 1'b1; desvio = 1'b1; deslocamento = 26'h2;
    ciclo();
    verificar("eret_exec_pc", 32'(pcAtual), 32'hB);
    verificar("eret_exec_flag", 32'(em_interrupcao), 32'h0);

    ir_para(26'h7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ciclo();
      verificar("stall", 32'(pcAtual), 32'h7);
    end
    ocioso(); halt = 1'b1;
    ciclo();
    verificar("halt_parado", 32'(parado), 32'h1);
    verificar("halt_pc", 32'(pcAtual), 32'h7);
    ocioso(); interrupcao = 1'b1; salto = 1'b1; eret = 1'b1; endereco = 26'h55;
    for (int i = 0; i < 2; i++) begin
      ciclo();
      verificar("parado_pc", 32'(pcAtual), 32'h7);
      verificar("parado_int", 32'(em_interrupcao), 32'h0);
    end
    #2; reset_n = 1'b0; #1;
    verificar("parado_rst_pc", 32'(pcAtual), 32'h0);
    verificar("parado_rst_flag", 32'(parado), 32'h0);
    reset_n = 1'b1;
    ocioso();

    $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falha);
    $finish;
  end

endmodule
